// File: rtl/uncore_l3_arbiter.sv
// uncore_l3_arbiter
//   Front end that merges NUM_CH core request channels onto the single L3
//   request port. Picks one channel per cycle round-robin, registers the
//   winner into an L3 request stage that holds under backpressure, and keeps
//   a FIFO of issued channel tags so the in-order L3 responses can be steered
//   back to the channel that owns them.
//
// Ports
//   clk, rst                          clock, async active-high reset
//   req_valid/ready/we/addr/wdata     per-channel request side (addr/wdata packed)
//   l3_req_valid/ready/we/addr/wdata  registered request to L3
//   l3_rsp_valid, l3_rsp_rdata        in-order responses from L3
//   rsp_valid, rsp_rdata              one-hot response strobe, broadcast data
//   outstanding                       tag FIFO occupancy
//   err_orphan_rsp                    sticky: response arrived with no tag queued
module uncore_l3_arbiter #(
  parameter int NUM_CH          = 4,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 64,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_CH-1:0]                    req_valid,
  output logic [NUM_CH-1:0]                    req_ready,
  input  logic [NUM_CH-1:0]                    req_we,
  input  logic [NUM_CH*ADDR_W-1:0]             req_addr,
  input  logic [NUM_CH*DATA_W-1:0]             req_wdata,
  output logic                                 l3_req_valid,
  input  logic                                 l3_req_ready,
  output logic                                 l3_req_we,
  output logic [ADDR_W-1:0]                    l3_req_addr,
  output logic [DATA_W-1:0]                    l3_req_wdata,
  input  logic                                 l3_rsp_valid,
  input  logic [DATA_W-1:0]                    l3_rsp_rdata,
  output logic [NUM_CH-1:0]                    rsp_valid,
  output logic [DATA_W-1:0]                    rsp_rdata,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
  output logic                                 err_orphan_rsp
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [CH_W-1:0]   rr_q, rr_d;
  logic              l3_valid_q, l3_valid_d;
  logic              l3_we_q, l3_we_d;
  logic [ADDR_W-1:0] l3_addr_q, l3_addr_d;
  logic [DATA_W-1:0] l3_wdata_q, l3_wdata_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [CH_W-1:0]   tag_q [MAX_OUTSTANDING];

  logic              slot_free;
  logic              can_grant;
  logic              gnt_found;
  logic [CH_W-1:0]   gnt_idx;
  logic              push;
  logic              pop;

  function automatic logic [CH_W-1:0] wrap_idx(input logic [CH_W-1:0] base,
                                               input int unsigned     off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= unsigned'(NUM_CH)) s = s - unsigned'(NUM_CH);
    return CH_W'(s);
  endfunction

  // The full check deliberately uses the pre-pop count: a response popping
  // this cycle does not open a grant until the next cycle.
  assign slot_free = !l3_valid_q || l3_req_ready;
  assign can_grant = !rst && slot_free && (cnt_q < CNT_W'(MAX_OUTSTANDING));

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    if (can_grant) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!gnt_found && req_valid[wrap_idx(rr_q, i)]) begin
          gnt_found = 1'b1;
          gnt_idx   = wrap_idx(rr_q, i);
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (gnt_found) req_ready[gnt_idx] = 1'b1;
  end

  assign push = gnt_found;
  assign pop  = l3_rsp_valid && (cnt_q != '0);

  always_comb begin
    rr_d       = rr_q;
    l3_valid_d = l3_valid_q;
    l3_we_d    = l3_we_q;
    l3_addr_d  = l3_addr_q;
    l3_wdata_d = l3_wdata_q;
    if (gnt_found) begin
      rr_d       = (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
      l3_valid_d = 1'b1;
      l3_we_d    = req_we[gnt_idx];
      l3_addr_d  = req_addr[gnt_idx*ADDR_W +: ADDR_W];
      l3_wdata_d = req_wdata[gnt_idx*DATA_W +: DATA_W];
    end else if (l3_valid_q && l3_req_ready) begin
      l3_valid_d = 1'b0;
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q;
    if (push && !pop) cnt_d = cnt_q + 1'b1;
    if (!push && pop) cnt_d = cnt_q - 1'b1;
    err_d    = err_q || (l3_rsp_valid && (cnt_q == '0));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q       <= '0;
      l3_valid_q <= 1'b0;
      l3_we_q    <= 1'b0;
      l3_addr_q  <= '0;
      l3_wdata_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      rr_q       <= rr_d;
      l3_valid_q <= l3_valid_d;
      l3_we_q    <= l3_we_d;
      l3_addr_q  <= l3_addr_d;
      l3_wdata_q <= l3_wdata_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  // Tag storage needs no reset: entries are only read while the count says
  // they were written.
  always_ff @(posedge clk) begin
    if (push) tag_q[wr_ptr_q] <= gnt_idx;
  end

  always_comb begin
    rsp_valid = '0;
    if (pop) rsp_valid[tag_q[rd_ptr_q]] = 1'b1;
  end

  assign rsp_rdata      = l3_rsp_rdata;
  assign l3_req_valid   = l3_valid_q;
  assign l3_req_we      = l3_we_q;
  assign l3_req_addr    = l3_addr_q;
  assign l3_req_wdata   = l3_wdata_q;
  assign outstanding    = cnt_q;
  assign err_orphan_rsp = err_q;

endmodule

// File: tb/tb_uncore_l3_arbiter.sv
module tb_uncore_l3_arbiter;
  localparam int NCH  = 4;
  localparam int AW   = 32;
  localparam int DW   = 64;
  localparam int MAXO = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH-1:0]    req_valid, req_ready, req_we;
  logic [NCH*AW-1:0] req_addr;
  logic [NCH*DW-1:0] req_wdata;
  logic              l3_req_valid, l3_req_ready, l3_req_we;
  logic [AW-1:0]     l3_req_addr;
  logic [DW-1:0]     l3_req_wdata;
  logic              l3_rsp_valid;
  logic [DW-1:0]     l3_rsp_rdata;
  logic [NCH-1:0]    rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic [2:0]        outstanding;
  logic              err_orphan_rsp;

  uncore_l3_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .l3_req_valid(l3_req_valid), .l3_req_ready(l3_req_ready), .l3_req_we(l3_req_we),
    .l3_req_addr(l3_req_addr), .l3_req_wdata(l3_req_wdata),
    .l3_rsp_valid(l3_rsp_valid), .l3_rsp_rdata(l3_rsp_rdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .outstanding(outstanding), .err_orphan_rsp(err_orphan_rsp)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // requester-side stimulus: a pending request is held until granted
  bit          pend  [NCH];
  bit          pwe   [NCH];
  logic [31:0] paddr [NCH];
  logic [63:0] pdata [NCH];
  bit          l3_rdy;
  bit          rsp_v;
  logic [63:0] rsp_data;

  // reference model
  int          m_rr;
  int          m_tags[$];
  bit          m_hv, m_we, m_err;
  logic [31:0] m_addr;
  logic [63:0] m_data;
  logic [32:0] acc[$];

  int             last_gnt;
  logic [NCH-1:0] obs_rdy, obs_rsp;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic arm(input int c, input bit we, input logic [31:0] a, input logic [63:0] d);
    pend[c] = 1'b1; pwe[c] = we; paddr[c] = a; pdata[c] = d;
  endtask

  task automatic arm_idle_random();
    for (int c = 0; c < NCH; c++)
      if (!pend[c]) arm(c, 1'($urandom_range(0, 1)), $urandom, {$urandom, $urandom});
  endtask

  task automatic step();
    int             g, c;
    logic [NCH-1:0] erdy, ersp;
    @(negedge clk);
    for (int i = 0; i < NCH; i++) begin
      req_valid[i]           = pend[i];
      req_we[i]              = pwe[i];
      req_addr[i*AW +: AW]   = paddr[i];
      req_wdata[i*DW +: DW]  = pdata[i];
    end
    l3_req_ready = l3_rdy;
    l3_rsp_valid = rsp_v;
    l3_rsp_rdata = rsp_data;
    g = -1;
    if ((!m_hv || l3_rdy) && m_tags.size() < MAXO)
      for (int k = 0; k < NCH; k++) begin
        c = (m_rr + k) % NCH;
        if (g < 0 && pend[c]) g = c;
      end
    erdy = '0;
    if (g >= 0) erdy[g] = 1'b1;
    ersp = '0;
    if (rsp_v && m_tags.size() > 0) ersp[m_tags[0]] = 1'b1;
    #1;
    obs_rdy = req_ready;
    obs_rsp = rsp_valid;
    chk("req_ready", req_ready, erdy);
    chk("rsp_valid", rsp_valid, ersp);
    if (rsp_v) chk("rsp_rdata", rsp_rdata, rsp_data);
    chk("l3_req_valid", l3_req_valid, m_hv);
    if (m_hv) begin
      chk("l3_req_we", l3_req_we, m_we);
      chk("l3_req_addr", l3_req_addr, m_addr);
      chk("l3_req_wdata", l3_req_wdata, m_data);
    end
    chk("outstanding", outstanding, m_tags.size());
    chk("err_orphan", err_orphan_rsp, m_err);
    last_gnt = g;
    if (m_hv && l3_rdy) acc.push_back({m_we, m_addr});
    if (rsp_v) begin
      if (m_tags.size() == 0) m_err = 1'b1;
      else void'(m_tags.pop_front());
    end
    if (g >= 0) begin
      m_tags.push_back(g);
      m_hv = 1'b1; m_we = pwe[g]; m_addr = paddr[g]; m_data = pdata[g];
      m_rr = (g + 1) % NCH;
      pend[g] = 1'b0;
    end else if (m_hv && l3_rdy) begin
      m_hv = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_l3_valid", l3_req_valid, 0);
    chk("rst_l3_we", l3_req_we, 0);
    chk("rst_l3_addr", l3_req_addr, 0);
    chk("rst_l3_wdata", l3_req_wdata, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_err", err_orphan_rsp, 0);
    m_rr = 0; m_tags.delete(); m_hv = 0; m_err = 0; m_we = 0; m_addr = '0; m_data = '0;
    @(posedge clk);
    @(negedge clk);
    req_valid = '0; l3_rsp_valid = 1'b0; rsp_v = 1'b0;
    rst = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < NCH; c++) pend[c] = 1'b0;
    l3_rdy = 1'b1;
    for (int n = 0; n < 20 && (m_tags.size() > 0 || m_hv); n++) begin
      rsp_v = (m_tags.size() > 0);
      step();
    end
    rsp_v = 1'b0;
    chk("drain_done", m_tags.size() + int'(m_hv), 0);
  endtask

  initial begin
    int ngr;
    int gseq[$];
    rst = 1'b1;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    l3_req_ready = 1'b0; l3_rsp_valid = 1'b0; l3_rsp_rdata = '0;
    for (int c = 0; c < NCH; c++) pend[c] = 1'b0;
    l3_rdy = 1'b1; rsp_v = 1'b0; rsp_data = '0;
    repeat (2) @(posedge clk);
    do_reset();

    // orphan response: no strobe, sticky error
    rsp_v = 1'b1; rsp_data = 64'h55;
    step();
    chk("orphan_no_strobe", obs_rsp, 0);
    rsp_v = 1'b0;
    step();
    step();
    chk("orphan_sticky", err_orphan_rsp, 1);

    // all channels requesting, responses trail by two
    do_reset();
    gseq.delete();
    for (int n = 0; n < 8; n++) begin
      arm_idle_random();
      rsp_v = (m_tags.size() >= 2);
      rsp_data = {$urandom, $urandom};
      step();
      gseq.push_back(last_gnt);
    end
    for (int n = 0; n < 8; n++) chk("rr_order", gseq[n], n % 4);
    drain();

    // single channel under L3 backpressure
    arm(2, 1'b0, 32'hCAFE_0200, 64'h0);
    l3_rdy = 1'b0;
    step();
    chk("bp_first_grant", last_gnt, 2);
    arm(2, 1'b1, 32'hCAFE_0204, 64'h77);
    ngr = 0;
    repeat (3) begin
      step();
      if (last_gnt >= 0) ngr++;
      chk("bp_hold_addr", l3_req_addr, 32'hCAFE_0200);
    end
    chk("bp_no_regrant", ngr, 0);
    l3_rdy = 1'b1;
    step();
    chk("bp_regrant", last_gnt, 2);
    drain();

    // outstanding limit, pop does not free a same-cycle grant
    do_reset();
    ngr = 0;
    repeat (6) begin
      arm_idle_random();
      step();
      if (last_gnt >= 0) ngr++;
    end
    chk("full_grants", ngr, 4);
    chk("full_outstanding", outstanding, 4);
    rsp_v = 1'b1; rsp_data = 64'h1;
    step();
    chk("full_pop_no_grant", obs_rdy, 4'b0000);
    rsp_v = 1'b0;
    step();
    chk("full_grant_after_pop", obs_rdy, 4'b0001);
    drain();

    // write on ch1 followed by read on ch3 to the same address
    do_reset();
    for (int c = 0; c < NCH; c++) pend[c] = 1'b0;
    acc.delete();
    arm(1, 1'b1, 32'h100, 64'hDEADBEEF);
    arm(3, 1'b0, 32'h100, 64'h0);
    l3_rdy = 1'b1;
    step(); chk("wr_grant", obs_rdy, 4'b0010);
    step(); chk("rd_grant", obs_rdy, 4'b1000);
    step();
    rsp_v = 1'b1; rsp_data = 64'h0;
    step(); chk("wr_rsp_route", obs_rsp, 4'b0010);
    rsp_data = 64'hDEADBEEF;
    step(); chk("rd_rsp_route", obs_rsp, 4'b1000);
    chk("rd_rsp_data", rsp_rdata, 64'hDEADBEEF);
    rsp_v = 1'b0;
    chk("l3_order_n", acc.size(), 2);
    if (acc.size() == 2) begin
      chk("l3_order_0", acc[0], {1'b1, 32'h100});
      chk("l3_order_1", acc[1], {1'b0, 32'h100});
    end

    // randomized traffic
    repeat (300) begin
      for (int c = 0; c < NCH; c++)
        if (!pend[c] && $urandom_range(0, 1) == 1)
          arm(c, 1'($urandom_range(0, 1)), $urandom, {$urandom, $urandom});
      l3_rdy   = ($urandom_range(0, 3) != 0);
      rsp_v    = (m_tags.size() > 0) && ($urandom_range(0, 2) == 0);
      rsp_data = {$urandom, $urandom};
      step();
    end

    // reset in the middle of traffic, then ch0 has priority again
    do_reset();
    for (int c = 0; c < NCH; c++) arm(c, 1'b0, 32'h4000 + c, 64'h0);
    l3_rdy = 1'b1;
    step();
    chk("rst_rr_ch0", obs_rdy, 4'b0001);
    step();
    chk("rst_rr_ch1", obs_rdy, 4'b0010);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
